mem_port_arbiter: RTL and testbench

- Sequences the single shared instruction/data memory port between two requesters: the IF-stage fetch and the MEM-stage load/store.
- Replaces clock-phase multiplexing of the memory address with a registered, request/valid-handshaked arbiter.
- Produces stall signals that the pipeline uses to freeze PC, IF/ID and EX/MEM while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared instruction/data memory port between fetch and load/store.
// Data side wins from IDLE; after each completion only the other side may be granted.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state  | meaning
    // IDLE   | port free, arbitrate with data priority
    // BUSY_I | fetch command on the port, counting MEM_LAT cycles
    // BUSY_D | load/store command on the port, counting MEM_LAT cycles
    // DONE_I | if_valid pulse; only the data side may be granted
    // DONE_D | d_valid pulse; only the fetch side may be granted
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [2:0] FETCH_FUNC3 = 3'b010;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_i;
    logic grant_d;
    logic busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            func3_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            func3_q    <= func3_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    if_rdata_d = mem_rdata;
                    state_d    = DONE_I;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY_D: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE_D;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The requester just served is deliberately not looked at here.
            DONE_I: begin
                if (d_req) begin
                    grant_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE_D: begin
                if (if_req) begin
                    grant_i = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_d) begin
            state_d = BUSY_D;
            cnt_d   = '0;
            addr_d  = d_addr;
            func3_d = d_func3;
            wdata_d = d_wdata;
            we_d    = d_we;
        end else if (grant_i) begin
            state_d = BUSY_I;
            cnt_d   = '0;
            addr_d  = if_addr;
            func3_d = FETCH_FUNC3;
            wdata_d = '0;
            we_d    = 1'b0;
        end
    end

    // Port outputs come only from the command registers so they cannot move mid-access.
    assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_addr  = addr_q;
    assign mem_func3 = func3_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = busy & ~we_q;
    assign mem_write = busy & we_q;

    assign if_valid = (state_q == DONE_I);
    assign d_valid  = (state_q == DONE_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Stalls are masked while reset is held so every output reads zero in reset.
    assign if_stall = if_req & ~if_valid & rst;
    assign d_stall  = d_req & ~d_valid & rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// sharing stimulus; each test resets or idles both before driving its own scenario.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_func3 = '0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] if_rdata1, d_rdata1, mem_wdata1;
    logic        if_valid1, if_stall1, d_valid1, d_stall1, mem_read1, mem_write1;
    logic [7:0]  mem_addr1;
    logic [2:0]  mem_func31;

    logic [31:0] if_rdata3, d_rdata3, mem_wdata3;
    logic        if_valid3, if_stall3, d_valid3, d_stall3, mem_read3, mem_write3;
    logic [7:0]  mem_addr3;
    logic [2:0]  mem_func33;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_valid(if_valid1), .if_stall(if_stall1),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_valid(d_valid1), .d_stall(d_stall1),
        .mem_addr(mem_addr1), .mem_read(mem_read1), .mem_write(mem_write1), .mem_func3(mem_func31),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3), .if_stall(if_stall3),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_valid(d_valid3), .d_stall(d_stall3),
        .mem_addr(mem_addr3), .mem_read(mem_read3), .mem_write(mem_write3), .mem_func3(mem_func33),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        checks++; if ({if_valid1, d_valid1, if_stall1, d_stall1, mem_read1, mem_write1} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 000000",
                {if_valid1, d_valid1, if_stall1, d_stall1, mem_read1, mem_write1}); end
        checks++; if ({mem_addr1, mem_func31, mem_wdata1} !== 43'b0) begin
            failures++; $display("FAIL reset_cmd: got %h/%h/%h expected 0", mem_addr1, mem_func31, mem_wdata1); end
        checks++; if ({if_rdata1, d_rdata1} !== 64'b0) begin
            failures++; $display("FAIL reset_rdata: got %h/%h expected 0", if_rdata1, d_rdata1); end
        do_reset();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 8'h10; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        checks++; if ({if_stall1, mem_read1, if_valid1} !== 3'b100) begin
            failures++; $display("FAIL fetch_c0: stall/read/valid got %b expected 100", {if_stall1, mem_read1, if_valid1}); end
        next_cycle(); @(negedge clk);
        checks++; if ({if_stall1, mem_read1, mem_write1, if_valid1} !== 4'b1100 || mem_addr1 !== 8'h10 || mem_func31 !== 3'b010) begin
            failures++; $display("FAIL fetch_c1: ctl %b addr %h f3 %b expected 1100 10 010",
                {if_stall1, mem_read1, mem_write1, if_valid1}, mem_addr1, mem_func31); end
        next_cycle(); @(negedge clk);
        checks++; if ({if_stall1, mem_read1, if_valid1} !== 3'b001 || if_rdata1 !== 32'h0050_0093) begin
            failures++; $display("FAIL fetch_c2: ctl %b rdata %h expected 001 00500093", {if_stall1, mem_read1, if_valid1}, if_rdata1); end
        if_req = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if ({if_valid1, mem_read1} !== 2'b00 || if_rdata1 !== 32'h0050_0093) begin
            failures++; $display("FAIL fetch_hold: valid/read %b rdata %h expected 00 00500093", {if_valid1, mem_read1}, if_rdata1); end
        next_cycle();
    endtask

    task automatic test_both();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_func3 = 3'b100;
        if_req = 1'b1; if_addr = 8'h14; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        checks++; if ({if_stall1, d_stall1} !== 2'b11) begin
            failures++; $display("FAIL both_c0: stalls got %b expected 11", {if_stall1, d_stall1}); end
        next_cycle(); @(negedge clk);
        checks++; if (mem_read1 !== 1'b1 || mem_addr1 !== 8'h20 || mem_func31 !== 3'b100 || {if_stall1, d_stall1} !== 2'b11) begin
            failures++; $display("FAIL both_c1: read %b addr %h f3 %b stalls %b expected 1 20 100 11",
                mem_read1, mem_addr1, mem_func31, {if_stall1, d_stall1}); end
        next_cycle(); @(negedge clk);
        checks++; if ({d_valid1, if_valid1, mem_read1, if_stall1, d_stall1} !== 5'b10010 || d_rdata1 !== 32'h1111_1111) begin
            failures++; $display("FAIL both_c2: ctl %b d_rdata %h expected 10010 11111111",
                {d_valid1, if_valid1, mem_read1, if_stall1, d_stall1}, d_rdata1); end
        d_req = 1'b0; mem_rdata = 32'h2222_2222;
        next_cycle(); @(negedge clk);
        checks++; if (mem_read1 !== 1'b1 || mem_addr1 !== 8'h14 || mem_func31 !== 3'b010 || if_stall1 !== 1'b1 || d_valid1 !== 1'b0) begin
            failures++; $display("FAIL both_c3: read %b addr %h f3 %b stall %b dv %b expected 1 14 010 1 0",
                mem_read1, mem_addr1, mem_func31, if_stall1, d_valid1); end
        next_cycle(); @(negedge clk);
        checks++; if ({if_valid1, d_valid1, if_stall1} !== 3'b100 || if_rdata1 !== 32'h2222_2222 || d_rdata1 !== 32'h1111_1111) begin
            failures++; $display("FAIL both_c4: ctl %b if_rdata %h d_rdata %h expected 100 22222222 11111111",
                {if_valid1, d_valid1, if_stall1}, if_rdata1, d_rdata1); end
        if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h24; d_wdata = 32'hDEAD_BEEF; d_func3 = 3'b010;
        mem_rdata = 32'h3333_3333;
        @(negedge clk);
        checks++; if ({mem_write1, mem_read1, d_stall1} !== 3'b001) begin
            failures++; $display("FAIL store_c0: write/read/stall got %b expected 001", {mem_write1, mem_read1, d_stall1}); end
        next_cycle(); @(negedge clk);
        checks++; if ({mem_write1, mem_read1} !== 2'b10 || mem_addr1 !== 8'h24 || mem_wdata1 !== 32'hDEAD_BEEF || mem_func31 !== 3'b010) begin
            failures++; $display("FAIL store_c1: wr/rd %b addr %h wdata %h f3 %b expected 10 24 deadbeef 010",
                {mem_write1, mem_read1}, mem_addr1, mem_wdata1, mem_func31); end
        next_cycle(); @(negedge clk);
        checks++; if ({d_valid1, mem_write1, mem_read1, d_stall1} !== 4'b1000 || d_rdata1 !== 32'h1111_1111) begin
            failures++; $display("FAIL store_c2: ctl %b d_rdata %h expected 1000 11111111",
                {d_valid1, mem_write1, mem_read1, d_stall1}, d_rdata1); end
        d_req = 1'b0; d_we = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if ({d_valid1, mem_write1} !== 2'b00) begin
            failures++; $display("FAIL store_after: valid/write got %b expected 00", {d_valid1, mem_write1}); end
        next_cycle();
    endtask

    task automatic test_lat3();
        do_reset();
        if_req = 1'b1; if_addr = 8'h08; mem_rdata = 32'hCAFE_0008;
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) if_addr = 8'h0C;
            @(negedge clk);
            checks++; if (mem_read3 !== 1'b1 || mem_addr3 !== 8'h08 || if_valid3 !== 1'b0 || if_stall3 !== 1'b1) begin
                failures++; $display("FAIL lat3_c%0d: read %b addr %h valid %b stall %b expected 1 08 0 1",
                    c, mem_read3, mem_addr3, if_valid3, if_stall3); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({if_valid3, mem_read3, if_stall3} !== 3'b100 || if_rdata3 !== 32'hCAFE_0008) begin
            failures++; $display("FAIL lat3_c4: ctl %b rdata %h expected 100 cafe0008", {if_valid3, mem_read3, if_stall3}, if_rdata3); end
        if_req = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if (if_valid3 !== 1'b0) begin
            failures++; $display("FAIL lat3_pulse: if_valid got %b expected 0", if_valid3); end
    endtask

    task automatic test_alternate();
        logic exp_d, exp_i;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40; d_func3 = 3'b010;
        if_req = 1'b1; if_addr = 8'h00; mem_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp_d = (c >= 2) && (c % 4 == 2);
            exp_i = (c >= 4) && (c % 4 == 0);
            checks++; if ({d_valid1, if_valid1} !== {exp_d, exp_i}) begin
                failures++; $display("FAIL alt_c%0d: d_valid/if_valid got %b expected %b", c, {d_valid1, if_valid1}, {exp_d, exp_i}); end
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h1234_5678; d_func3 = 3'b010;
        next_cycle(); @(negedge clk);
        checks++; if ({mem_write1, mem_write3} !== 2'b11) begin
            failures++; $display("FAIL rmid_pre: mem_write got %b expected 11", {mem_write1, mem_write3}); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_write1, mem_read1, d_valid1, d_stall1, mem_write3, d_stall3} !== 6'b0 ||
                      mem_addr1 !== 8'h00 || mem_wdata1 !== 32'h0 || mem_addr3 !== 8'h00) begin
            failures++; $display("FAIL rmid_async: ctl %b addr %h wdata %h addr3 %h expected 0",
                {mem_write1, mem_read1, d_valid1, d_stall1, mem_write3, d_stall3}, mem_addr1, mem_wdata1, mem_addr3); end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_cycle(); @(negedge clk);
            checks++; if ({d_valid1, d_valid3, mem_write1, mem_write3} !== 4'b0) begin
                failures++; $display("FAIL rmid_post_c%0d: valid/write got %b expected 0000",
                    c, {d_valid1, d_valid3, mem_write1, mem_write3}); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_store();
        test_lat3();
        test_alternate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
